// File: rtl/ordena_serial_8_num_pkg.sv
// Shared types and the compare-exchange rule for the serial odd-even transposition sorter.
package ordena_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        SORT  = 2'd1,
        DRAIN = 2'd2
    } estado_t;

    localparam logic CRESCENTE   = 1'b1;
    localparam logic DECRESCENTE = 1'b0;

    // Widest value troca() handles; narrower operands are zero-extended, keeping the unsigned order.
    localparam int unsigned MAX_W = 32;

    typedef struct packed {
        logic [MAX_W-1:0] primeiro;
        logic [MAX_W-1:0] segundo;
    } par_t;

    function automatic par_t troca(input logic [MAX_W-1:0] a,
                                   input logic [MAX_W-1:0] b,
                                   input logic             dir);
        par_t r;
        logic trocar;
        trocar     = (dir == CRESCENTE) ? (a > b) : (a < b);
        r.primeiro = trocar ? b : a;
        r.segundo  = trocar ? a : b;
        return r;
    endfunction

endpackage

// File: rtl/ordena_serial_8_num_if.sv
// Load/drain handshake bundle of the serial sorter.
interface ordena_serial_8_num_if #(
    parameter int unsigned WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             out_last;

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_last
    );

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_last
    );
endinterface

// File: rtl/ordena_serial_8_num_par_reg.sv
// One compare-exchange cell; when disabled both values pass through unchanged.
module ordena_par_reg
    import ordena_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic             en_i,
    input  logic             dir_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic [WIDTH-1:0] lo_o,
    output logic [WIDTH-1:0] hi_o
);

    par_t par;

    assign par  = troca(MAX_W'(a_i), MAX_W'(b_i), dir_i);
    assign lo_o = en_i ? par.primeiro[WIDTH-1:0] : a_i;
    assign hi_o = en_i ? par.segundo[WIDTH-1:0]  : b_i;

    // Zero-extension padding is always zero after the exchange.
    if (WIDTH < MAX_W) begin : g_pad
        logic unused_pad;
        assign unused_pad = ^{par.primeiro[MAX_W-1:WIDTH], par.segundo[MAX_W-1:WIDTH]};
    end

endmodule

// File: rtl/ordena_serial_8_num.sv
// Serial frame sorter: load N values, N odd-even transposition passes in place, then drain.
module ordena_serial_8_num
    import ordena_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned N     = 8
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         ena,
    input  logic                         cresc_ou_decres,
    output logic                         ocupado,
    ordena_serial_8_num_if.slave         bus
);

    localparam int unsigned CW = $clog2(N);
    typedef logic [CW-1:0] idx_t;
    localparam idx_t ULTIMO = idx_t'(N - 1);

    estado_t          estado_q, estado_d;
    idx_t             carga_q,  carga_d;
    idx_t             passo_q,  passo_d;
    idx_t             saida_q,  saida_d;
    logic             dir_q,    dir_d;
    logic [WIDTH-1:0] mem_q [N];
    logic [WIDTH-1:0] mem_d [N];

    logic [N-2:0]     cel_en;
    logic [WIDTH-1:0] cel_lo [N-1];
    logic [WIDTH-1:0] cel_hi [N-1];
    logic             aceita;
    logic             entrega;

    assign bus.in_ready  = rst_n && ena && (estado_q == LOAD);
    assign bus.out_valid = ena && (estado_q == DRAIN);
    assign bus.out_data  = bus.out_valid ? mem_q[saida_q] : '0;
    assign bus.out_last  = bus.out_valid && (saida_q == ULTIMO);
    assign ocupado       = (estado_q == SORT) || (estado_q == DRAIN);

    assign aceita  = bus.in_valid && bus.in_ready;
    assign entrega = bus.out_valid && bus.out_ready;

    // Cell i owns pair (i, i+1); even passes enable even cells, odd passes odd cells.
    for (genvar i = 0; i < N - 1; i++) begin : g_cel
        assign cel_en[i] = (estado_q == SORT) && (passo_q[0] == 1'(i % 2));

        ordena_par_reg #(.WIDTH(WIDTH)) u_cel (
            .en_i  (cel_en[i]),
            .dir_i (dir_q),
            .a_i   (mem_q[i]),
            .b_i   (mem_q[i+1]),
            .lo_o  (cel_lo[i]),
            .hi_o  (cel_hi[i])
        );
    end

    always_comb begin
        estado_d = estado_q;
        carga_d  = carga_q;
        passo_d  = passo_q;
        saida_d  = saida_q;
        dir_d    = dir_q;
        mem_d    = mem_q;

        if (!ena) begin
            estado_d = LOAD;
            carga_d  = '0;
            passo_d  = '0;
            saida_d  = '0;
        end else begin
            case (estado_q)
                LOAD: begin
                    if (aceita) begin
                        mem_d[carga_q] = bus.in_data;
                        if (carga_q == '0) dir_d = cresc_ou_decres;
                        if (carga_q == ULTIMO) begin
                            carga_d  = '0;
                            estado_d = SORT;
                        end else begin
                            carga_d = carga_q + 1'b1;
                        end
                    end
                end
                SORT: begin
                    for (int j = 0; j < N - 1; j++) begin
                        if (cel_en[j]) begin
                            mem_d[j]   = cel_lo[j];
                            mem_d[j+1] = cel_hi[j];
                        end
                    end
                    if (passo_q == ULTIMO) begin
                        passo_d  = '0;
                        estado_d = DRAIN;
                    end else begin
                        passo_d = passo_q + 1'b1;
                    end
                end
                DRAIN: begin
                    if (entrega) begin
                        if (saida_q == ULTIMO) begin
                            saida_d  = '0;
                            estado_d = LOAD;
                        end else begin
                            saida_d = saida_q + 1'b1;
                        end
                    end
                end
                default: estado_d = LOAD;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= LOAD;
            carga_q  <= '0;
            passo_q  <= '0;
            saida_q  <= '0;
            dir_q    <= CRESCENTE;
            for (int j = 0; j < N; j++) mem_q[j] <= '0;
        end else begin
            estado_q <= estado_d;
            carga_q  <= carga_d;
            passo_q  <= passo_d;
            saida_q  <= saida_d;
            dir_q    <= dir_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: tb/tb_ordena_serial_8_num.sv
// Randomized bench for ordena_serial_8_num against a queue-sort reference model.
module tb_ordena_serial_8_num;

    localparam int N = 8;
    localparam int W = 8;

    typedef int fila_t[$];

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic ena   = 1'b0;
    logic cresc = 1'b1;
    logic ocupado;

    int checks = 0;
    int errors = 0;

    ordena_serial_8_num_if #(.WIDTH(W)) bus ();

    ordena_serial_8_num #(.WIDTH(W), .N(N)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .ena             (ena),
        .cresc_ou_decres (cresc),
        .ocupado         (ocupado),
        .bus             (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    // ---------------- reference model and stimulus helpers ----------------
    function automatic fila_t modelo(input fila_t v, input logic dir);
        fila_t e;
        e = v;
        if (dir) e.sort();
        else     e.rsort();
        return e;
    endfunction

    function automatic bit igual(input fila_t a, input fila_t b);
        if (a.size() != b.size()) return 1'b0;
        foreach (a[i]) if (a[i] != b[i]) return 1'b0;
        return 1'b1;
    endfunction

    function automatic fila_t aleatorio(input int maxv);
        fila_t q;
        for (int i = 0; i < N; i++) q.push_back(int'($urandom_range(0, maxv)));
        return q;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int v);
        int k;
        k = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = W'(v);
        #0;
        while (!bus.in_ready && k < 40) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 40) begin
            errors++;
            $display("FAIL push_timeout in_ready=%0b required 1", bus.in_ready);
        end
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic wait_valid(output int k);
        k = 0;
        while (!bus.out_valid && k < 60) begin
            tick();
            k++;
        end
        checks++;
        if (k >= 60) begin
            errors++;
            $display("FAIL out_valid_timeout out_valid=%0b required 1", bus.out_valid);
        end
    endtask

    // mode 0: always ready, 1: ready pattern 1,0,0 repeating, 2: random ready
    task automatic drain(input int cnt, input int mode, output fila_t got,
                         output int lastpos, output int nlast, output int unstable);
        int         cyc;
        logic [W-1:0] held;
        bit         holding;
        got = {};
        lastpos = -1; nlast = 0; unstable = 0; cyc = 0; holding = 0; held = '0;
        while (got.size() < cnt && cyc < 200) begin
            bus.out_ready = (mode == 0) ? 1'b1 : (mode == 1) ? (cyc % 3 == 0) : 1'($urandom_range(0, 1));
            #0;
            if (holding && bus.out_data !== held) unstable++;
            if (bus.out_valid && bus.out_ready) begin
                if (bus.out_last) begin
                    nlast++;
                    lastpos = got.size();
                end
                got.push_back(int'(bus.out_data));
                holding = 0;
            end else if (bus.out_valid) begin
                held    = bus.out_data;
                holding = 1;
            end
            tick();
            cyc++;
        end
        bus.out_ready = 1'b1;
    endtask

    task automatic run_frame(input fila_t vals, input logic dir, input int mode,
                             output fila_t got, output int lat, output int lastpos,
                             output int nlast, output int unstable);
        cresc = dir;
        foreach (vals[i]) push(vals[i]);
        wait_valid(lat);
        drain(N, mode, got, lastpos, nlast, unstable);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b1;
        ena = 1'b1;
        #1 rst_n = 1'b0;
        #2;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0 || bus.out_data !== '0 ||
            bus.out_last !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs rdy=%0b vld=%0b data=%0d last=%0b ocup=%0b required all 0",
                     bus.in_ready, bus.out_valid, bus.out_data, bus.out_last, ocupado);
        end
        tick(); tick();
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL reset_release in_ready=%0b ocupado=%0b required 1/0", bus.in_ready, ocupado);
        end
        tick();
    endtask

    task automatic test_ascending();
        fila_t vals, got, exp;
        int lat, lp, nl, us;
        vals = '{7, 3, 9, 1, 8, 2, 6, 4};
        exp  = '{1, 2, 3, 4, 6, 7, 8, 9};
        run_frame(vals, 1'b1, 0, got, lat, lp, nl, us);
        checks++;
        if (lat != N) begin
            errors++;
            $display("FAIL asc_latency cycles=%0d required %0d", lat, N);
        end
        checks++;
        if (!igual(got, exp)) begin
            errors++;
            $display("FAIL asc_data got=%p required %p", got, exp);
        end
        checks++;
        if (lp != N - 1 || nl != 1) begin
            errors++;
            $display("FAIL asc_last pos=%0d count=%0d required %0d/1", lp, nl, N - 1);
        end
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL asc_back_to_load rdy=%0b vld=%0b ocup=%0b required 1/0/0",
                     bus.in_ready, bus.out_valid, ocupado);
        end
    endtask

    task automatic test_descending();
        fila_t vals, got, exp;
        int lat, lp, nl, us;
        vals = '{10, 200, 0, 255, 5, 5, 128, 1};
        exp  = '{255, 200, 128, 10, 5, 5, 1, 0};
        run_frame(vals, 1'b0, 0, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, exp)) begin
            errors++;
            $display("FAIL desc_data got=%p required %p", got, exp);
        end
        checks++;
        if (lp != N - 1 || nl != 1 || got.size() != N || got[N-1] != 0) begin
            errors++;
            $display("FAIL desc_last pos=%0d count=%0d required %0d/1 on value 0", lp, nl, N - 1);
        end
    endtask

    task automatic test_backpressure();
        fila_t vals, got;
        int lat, lp, nl, us;
        vals = aleatorio(255);
        run_frame(vals, 1'b1, 1, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, modelo(vals, 1'b1))) begin
            errors++;
            $display("FAIL bp_data got=%p required %p", got, modelo(vals, 1'b1));
        end
        checks++;
        if (us != 0) begin
            errors++;
            $display("FAIL bp_stable changes=%0d required 0", us);
        end
        checks++;
        if (lp != N - 1 || nl != 1) begin
            errors++;
            $display("FAIL bp_last pos=%0d count=%0d required %0d/1", lp, nl, N - 1);
        end
    endtask

    task automatic test_dir_latch();
        fila_t vals, got;
        int lat, lp, nl, us;
        vals = aleatorio(255);
        cresc = 1'b1;
        for (int i = 0; i < 3; i++) push(vals[i]);
        cresc = 1'b0;
        for (int i = 3; i < N; i++) push(vals[i]);
        wait_valid(lat);
        drain(N, 0, got, lp, nl, us);
        checks++;
        if (!igual(got, modelo(vals, 1'b1))) begin
            errors++;
            $display("FAIL dir_latch got=%p required %p", got, modelo(vals, 1'b1));
        end
    endtask

    task automatic test_abort();
        fila_t vals, got, exp;
        int lat, lp, nl, us;

        // mid-LOAD
        cresc = 1'b1;
        for (int i = 0; i < 5; i++) push(int'($urandom_range(100, 255)));
        ena = 1'b0;
        #1;
        checks++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_ena0 rdy=%0b vld=%0b required 0/0", bus.in_ready, bus.out_valid);
        end
        tick();
        ena = 1'b1;
        vals = '{8, 7, 6, 5, 4, 3, 2, 1};
        exp  = '{1, 2, 3, 4, 5, 6, 7, 8};
        run_frame(vals, 1'b1, 0, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, exp) || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_load_data got=%p vld_after=%0b required %p/0", got, bus.out_valid, exp);
        end

        // mid-SORT
        vals = aleatorio(255);
        cresc = 1'b1;
        foreach (vals[i]) push(vals[i]);
        tick(); tick(); tick();
        checks++;
        if (ocupado !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sort_busy ocupado=%0b vld=%0b required 1/0", ocupado, bus.out_valid);
        end
        ena = 1'b0;
        tick();
        ena = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL abort_sort_load rdy=%0b ocupado=%0b required 1/0", bus.in_ready, ocupado);
        end
        vals = aleatorio(255);
        run_frame(vals, 1'b0, 0, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, modelo(vals, 1'b0))) begin
            errors++;
            $display("FAIL abort_sort_data got=%p required %p", got, modelo(vals, 1'b0));
        end

        // mid-DRAIN
        vals = aleatorio(255);
        cresc = 1'b1;
        foreach (vals[i]) push(vals[i]);
        wait_valid(lat);
        drain(3, 0, got, lp, nl, us);
        ena = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0) begin
            errors++;
            $display("FAIL abort_drain_ena0 vld=%0b data=%0d required 0/0", bus.out_valid, bus.out_data);
        end
        tick();
        ena = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL abort_drain_load rdy=%0b vld=%0b required 1/0", bus.in_ready, bus.out_valid);
        end
        vals = aleatorio(255);
        run_frame(vals, 1'b1, 2, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, modelo(vals, 1'b1)) || nl != 1) begin
            errors++;
            $display("FAIL abort_drain_data got=%p lasts=%0d required %p/1", got, nl, modelo(vals, 1'b1));
        end
    endtask

    task automatic test_random();
        fila_t vals, got;
        int lat, lp, nl, us;
        logic dir;
        for (int f = 0; f < 6; f++) begin
            vals = aleatorio((f % 2 == 0) ? 15 : 255);
            dir  = 1'($urandom_range(0, 1));
            run_frame(vals, dir, 2, got, lat, lp, nl, us);
            checks++;
            if (!igual(got, modelo(vals, dir)) || us != 0 || lp != N - 1 || nl != 1 || lat != N) begin
                errors++;
                $display("FAIL random_frame%0d dir=%0b got=%p required %p unstable=%0d last=%0d/%0d lat=%0d",
                         f, dir, got, modelo(vals, dir), us, lp, nl, lat);
            end
        end
    endtask

    task automatic test_async_reset();
        fila_t vals, got;
        int lat, lp, nl, us;
        vals = aleatorio(255);
        cresc = 1'b1;
        foreach (vals[i]) push(vals[i]);
        wait_valid(lat);
        drain(2, 0, got, lp, nl, us);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_data !== '0 || ocupado !== 1'b0 || bus.in_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset vld=%0b data=%0d ocup=%0b rdy=%0b required 0/0/0/0",
                     bus.out_valid, bus.out_data, ocupado, bus.in_ready);
        end
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        checks++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL async_release rdy=%0b vld=%0b required 1/0", bus.in_ready, bus.out_valid);
        end
        tick();
        checks++;
        if (bus.in_ready !== 1'b1 || ocupado !== 1'b0) begin
            errors++;
            $display("FAIL async_first_edge rdy=%0b ocup=%0b required 1/0", bus.in_ready, ocupado);
        end
        vals = aleatorio(255);
        run_frame(vals, 1'b0, 0, got, lat, lp, nl, us);
        checks++;
        if (!igual(got, modelo(vals, 1'b0))) begin
            errors++;
            $display("FAIL async_after_data got=%p required %p", got, modelo(vals, 1'b0));
        end
    endtask

    initial begin
        test_reset();
        test_ascending();
        test_descending();
        test_backpressure();
        test_dir_latch();
        test_abort();
        test_random();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
